// File: rtl/ctrldp_test_pkg.sv
// Shared constants, state encoding and arctangent table
// for the 16-iteration rotation-mode CORDIC block.
package ctrldp_test_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 14;
    localparam int N_ITER = 16;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 5;

    // 1/prod(sqrt(1+2^-2i)) in Q2.14
    localparam logic signed [DATA_W-1:0] K_INIT = 16'sh26DD;

    localparam logic [IDX_W-1:0] ITER_LAST = IDX_W'(N_ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic signed [DATA_W-1:0] atan_lut(
        input logic [IDX_W-1:0] idx
    );
        logic signed [DATA_W-1:0] a;
        a = '0;
        unique case (idx)
            4'd0:  a = 16'sd12868;
            4'd1:  a = 16'sd7596;
            4'd2:  a = 16'sd4014;
            4'd3:  a = 16'sd2037;
            4'd4:  a = 16'sd1023;
            4'd5:  a = 16'sd512;
            4'd6:  a = 16'sd256;
            4'd7:  a = 16'sd128;
            4'd8:  a = 16'sd64;
            4'd9:  a = 16'sd32;
            4'd10: a = 16'sd16;
            4'd11: a = 16'sd8;
            4'd12: a = 16'sd4;
            4'd13: a = 16'sd2;
            4'd14: a = 16'sd1;
            4'd15: a = 16'sd0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ctrldp_test_if.sv
// Bundle of the CORDIC block's operand, control and result signals.
// The master drives the request; the slave returns the result.
interface ctrldp_test_if;
    import ctrldp_test_pkg::*;

    logic signed [DATA_W-1:0] z0;
    logic                     comp;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    logic                     stop;
    logic [1:0]               state;
    logic [IDX_W-1:0]         i;
    logic [CNT_W-1:0]         counter;

    modport master (
        output z0, comp,
        input  x, y, stop, state, i, counter
    );

    modport slave (
        input  z0, comp,
        output x, y, stop, state, i, counter
    );

endinterface

// File: rtl/ctrldp_test_cordic_atan_rom.sv
// Combinational arctangent ROM: atan(2^-idx) in Q2.14.
module cordic_atan_rom
    import ctrldp_test_pkg::*;
(
    input  logic [IDX_W-1:0]         idx_i,
    output logic signed [DATA_W-1:0] angle_o
);

    assign angle_o = atan_lut(idx_i);

endmodule

// File: rtl/ctrldp_test.sv
// Rotation-mode CORDIC: control FSM and x/y/z datapath computing
// x=cos(z0), y=sin(z0) over 16 comp-gated iterations.
module ctrldp_test
    import ctrldp_test_pkg::*;
(
    output logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y,
    output logic                     stop,
    output logic [1:0]               state,
    output logic [IDX_W-1:0]         i,
    output logic [CNT_W-1:0]         counter,
    input  logic signed [DATA_W-1:0] z0,
    input  logic                     reset,
    input  logic                     comp,
    input  logic                     clk
);

    state_e                   state_q, state_d;
    logic signed [DATA_W-1:0] x_q, x_d;
    logic signed [DATA_W-1:0] y_q, y_d;
    logic signed [DATA_W-1:0] z_q, z_d;
    logic [IDX_W-1:0]         i_q, i_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     stop_q, stop_d;

    logic signed [DATA_W-1:0] angle;
    logic signed [DATA_W-1:0] x_sh;
    logic signed [DATA_W-1:0] y_sh;

    cordic_atan_rom u_rom (
        .idx_i   (i_q),
        .angle_o (angle)
    );

    assign x_sh = x_q >>> i_q;
    assign y_sh = y_q >>> i_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (comp) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                x_d     = K_INIT;
                y_d     = '0;
                z_d     = z0;
                i_d     = '0;
                cnt_d   = '0;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                if (comp) begin
                    // both updates read the pre-update x_q/y_q
                    if (!z_q[DATA_W-1]) begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - angle;
                    end else begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + angle;
                    end
                    i_d   = i_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (i_q == ITER_LAST) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!comp) state_d = ST_IDLE;
            end
        endcase

        stop_d = (state_d == ST_DONE);
    end

    assign x       = x_q;
    assign y       = y_q;
    assign stop    = stop_q;
    assign state   = state_q;
    assign i       = i_q;
    assign counter = cnt_q;

endmodule

// File: tb/tb_ctrldp_test.sv
// Scoreboard bench for ctrldp_test: expected cos/sin pairs are queued
// when an angle is issued and compared when stop rises.
module tb_ctrldp_test;
    import ctrldp_test_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    ctrldp_test_if bus ();

    ctrldp_test dut (
        .x       (bus.x),
        .y       (bus.y),
        .stop    (bus.stop),
        .state   (bus.state),
        .i       (bus.i),
        .counter (bus.counter),
        .z0      (bus.z0),
        .reset   (reset),
        .comp    (bus.comp),
        .clk     (clk)
    );

    always #10 clk = ~clk;

    typedef struct {
        int x;
        int y;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, int obs, int exp, int tol = 0);
        int d;
        d = obs - exp;
        checks++;
        if (d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s got %0d want %0d (tol %0d)",
                     tag, obs, exp, tol);
        end
    endtask

    function automatic int sx(logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(int ex, int ey);
        exp_t e;
        e.x = ex;
        e.y = ey;
        sb.push_back(e);
    endtask

    // reference from real-valued trig on the Q2.14 angle
    task automatic push_model(logic [15:0] a);
        real ang;
        ang = $itor(sx(a)) / 16384.0;
        push_exp(int'($cos(ang) * 16384.0), int'($sin(ang) * 16384.0));
    endtask

    task automatic run(string tag, logic [15:0] a, bit tog);
        int   n;
        bit   done;
        bit   c;
        int   pc;
        int   pi_;
        logic [1:0] ps;
        exp_t e;
        n    = 0;
        done = 1'b0;
        bus.z0 = a;
        while (!done && n < 200) begin
            c  = tog ? (((n * 20) / 50) % 2 == 0) : 1'b1;
            bus.comp = c;
            ps  = bus.state;
            pc  = int'(bus.counter);
            pi_ = int'(bus.i);
            if (ps == 2'd2) bus.z0 = 16'($urandom);
            step();
            n++;
            if (tog && ps == 2'd2) begin
                chk({tag, "_cnt_step"}, int'(bus.counter), pc + int'(c));
                chk({tag, "_i_step"}, int'(bus.i), (pi_ + int'(c)) % 16);
            end
            if (bus.stop) done = 1'b1;
        end
        if (!done) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            if (!tog) chk({tag, "_latency"}, n, 18);
            chk({tag, "_state"}, int'(bus.state), 3);
            chk({tag, "_counter"}, int'(bus.counter), 16);
            chk({tag, "_i"}, int'(bus.i), 0);
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 0, 1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_x"}, sx(bus.x), e.x, 8);
                chk({tag, "_y"}, sx(bus.y), e.y, 8);
            end
        end
    endtask

    task automatic to_idle();
        bus.comp = 1'b0;
        step();
    endtask

    initial begin
        int hx;
        int hy;
        int n;
        bus.comp = 1'b0;
        bus.z0   = '0;
        reset    = 1'b1;
        step();
        step();
        chk("rst_x", sx(bus.x), 0);
        chk("rst_y", sx(bus.y), 0);
        chk("rst_i", int'(bus.i), 0);
        chk("rst_counter", int'(bus.counter), 0);
        chk("rst_stop", int'(bus.stop), 0);
        chk("rst_state", int'(bus.state), 0);
        reset = 1'b0;
        step();
        chk("idle_hold", int'(bus.state), 0);

        push_exp(16'sh2D41, 16'sh2D41);
        run("pi4", 16'h3243, 1'b0);

        hx = sx(bus.x);
        hy = sx(bus.y);
        bus.comp = 1'b1;
        step();
        chk("done_hold_state", int'(bus.state), 3);
        chk("done_hold_stop", int'(bus.stop), 1);
        to_idle();
        chk("drop_state", int'(bus.state), 0);
        chk("drop_stop", int'(bus.stop), 0);
        chk("drop_x", sx(bus.x), hx);
        chk("drop_y", sx(bus.y), hy);

        push_exp(16384, 0);
        run("zero", 16'h0000, 1'b0);
        to_idle();

        push_exp(11585, -11585);
        run("npi4", 16'hCDBD, 1'b0);
        to_idle();

        push_exp(16'sh2D41, 16'sh2D41);
        run("toggle", 16'h3243, 1'b1);
        to_idle();

        push_model(16'h1000);
        run("p025", 16'h1000, 1'b0);
        to_idle();

        push_model(16'hE000);
        run("n050", 16'hE000, 1'b0);
        to_idle();

        bus.z0   = 16'h3243;
        bus.comp = 1'b1;
        n = 0;
        while (!(bus.state == 2'd2 && bus.counter == 5'd7) && n < 40) begin
            step();
            n++;
        end
        chk("mid_reach7", int'(bus.counter), 7);
        reset = 1'b1;
        step();
        chk("mid_x", sx(bus.x), 0);
        chk("mid_y", sx(bus.y), 0);
        chk("mid_i", int'(bus.i), 0);
        chk("mid_counter", int'(bus.counter), 0);
        chk("mid_stop", int'(bus.stop), 0);
        chk("mid_state", int'(bus.state), 0);
        reset = 1'b0;
        bus.comp = 1'b0;
        step();
        chk("mid_idle", int'(bus.state), 0);

        push_exp(16'sh2D41, 16'sh2D41);
        run("restart", 16'h3243, 1'b0);
        to_idle();

        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
